router_tile_scheduler: RTL and testbench
========================================

// Module: router_tile_scheduler
// PURPOSE
// Parametrised successor to the router controller. Walks a rectangular output map (W x H) and
//   hands each output pixel to one systolic-array row, SA_HEIGHT pixels per batch.
// Adds stride, per-pixel input base address, channel-group looping and a valid/ready handshake.
// Sits between config registers and the input router. Waits for i_compute_done between batches.
// PARAMETERS
// SA_HEIGHT   4  rows per batch, >=2. RB=$clog2(SA_HEIGHT).
// ADDR_WIDTH  8  width of sizes, coordinates and addresses.
// STRIDE_W    2  width of i_stride.
// CH_W        4  width of channel-group count and index.
// PORTS
// i_clk           in   1           clock, rising edge
// i_rst           in   1           asynchronous reset, active-high
// i_en            in   1           start; sampled only in IDLE
// i_reg_clear     in   1           synchronous abort/clear to IDLE
// i_start_addr    in   ADDR_WIDTH  input-map base address
// i_i_width       in   ADDR_WIDTH  input row pitch, in words
// i_o_width       in   ADDR_WIDTH  output width W
// i_o_height      in   ADDR_WIDTH  output height H
// i_stride        in   STRIDE_W    convolution stride S (0 is treated as 1)
// i_ch_groups     in   CH_W        channel-group count C
// i_ready         in   1           router accepts the current pixel
// i_compute_done  in   1           batch compute finished; 1-cycle pulse
// o_valid         out  1           pixel descriptor valid
// o_row_number    out  RB          target SA row for the current pixel
// o_o_x, o_o_y    out  ADDR_WIDTH  output coordinates
// o_addr          out  ADDR_WIDTH  i_start_addr + y*S*i_i_width + x*S, mod 2^ADDR_WIDTH
// o_ch            out  CH_W        current channel group
// o_busy          out  1           high when the state is not IDLE
// o_done          out  1           high while in DONE
// BEHAVIOUR
// Reset (async, any state): state=IDLE; all outputs and counters 0.
// Config latching: config inputs are latched on the accepted i_en. Later input changes are ignored until IDLE.
// IDLE:
//   - i_en=1 with W, H and C all nonzero -> ISSUE next cycle.
//     Counters start at x=y=row=ch=0. o_valid=1 one cycle after the i_en edge.
//   - i_en=1 with any of W, H, C zero -> DONE next cycle; no pixel is issued.
// ISSUE:
//   - o_valid=1. Descriptor outputs are registered and hold stable while i_ready=0.
//   - On the cycle o_valid&&i_ready, advance the pixel: x+1; if x reaches W-1, wrap x=0 and y+1.
//   - Then, if row==SA_HEIGHT-1 or the last pixel (x=W-1, y=H-1) was taken: row=0, go WAIT.
//   - Otherwise row+1 and stay in ISSUE.
//   - The last batch may be partial; its final o_row_number is the partial count-1.
// WAIT:
//   - o_valid=0; waits for i_compute_done.
//   - Pixels remain -> ISSUE.
//   - Else ch<C-1 -> ch+1, x=y=0, then ISSUE.
//   - Else -> DONE.
// DONE: o_done=1 and is held until i_reg_clear (-> IDLE). i_en is ignored.
// i_compute_done outside WAIT is ignored. i_en outside IDLE is ignored.
// i_reg_clear in any state:
//   - -> IDLE next cycle; clears counters and outputs; o_valid=0 the next cycle.
//   - Has priority over the handshake and over i_compute_done in the same cycle.
// Address arithmetic:
//   - Incremental, with no multipliers: a row base is kept and x*S is added to it.
//   - All sums wrap modulo 2^ADDR_WIDTH.
// TESTING
// T1 Basic: W=H=4, S=1, i_i_width=6, start=0, C=1, i_ready=1, done pulse 3 cycles into WAIT
//    -> 4 batches of 4; batch 2 addrs 6,7,8,9, rows 0..3; then o_done=1.
// T2 Stride/partial: W=3, H=2, S=2, i_i_width=7, start=10
//    -> addrs 10,12,14,24 (rows 0-3), then 26,28 (rows 0-1); o_done after the 2nd done pulse.
// T3 Backpressure: i_ready=0 for 3 cycles mid-batch
//    -> o_valid stays 1 and x/y/addr/row are unchanged; advance only on the ready cycle.
// T4 Channels: W=H=2, C=3
//    -> the 4-pixel batch repeats with o_ch=0,1,2; o_done only after the 3rd compute_done.
// T5 Abort/reset: i_reg_clear during ISSUE with a simultaneous handshake -> IDLE, o_valid=0 next cycle.
//    i_rst asserted mid-WAIT -> all outputs 0 immediately. A fresh i_en restarts at x=y=0.
// T6 Zero size: i_en with H=0 -> o_done=1 next cycle, no o_valid; a stray i_compute_done is ignored.

Source files
------------

// File: rtl/router_tile_scheduler.sv
// -----------------------------------------------------------------------------
// router_tile_scheduler
//
// Walks a W x H output map in raster order and hands each output pixel to one
// systolic-array row. It issues up to SA_HEIGHT pixels per batch, then waits
// for the compute engine before issuing the next batch. The whole map is
// repeated once per channel group. Each pixel leaves on a valid/ready
// handshake as a registered descriptor: row, x, y, input address and channel.
//
// Input address = start + y*S*pitch + x*S (mod 2^ADDR_WIDTH). It is formed
// incrementally: a row base advances by S*pitch per output row, and an x
// offset advances by S per pixel.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_en                    start request, sampled only in IDLE
//   i_reg_clear             synchronous abort back to IDLE (highest priority)
//   i_start_addr            input-map base address
//   i_i_width               input row pitch in words
//   i_o_width, i_o_height   output map size W, H
//   i_stride                stride S (0 behaves as 1)
//   i_ch_groups             channel-group count C
//   i_ready                 router accepts the current descriptor
//   i_compute_done          one-cycle pulse: batch compute finished
//   o_valid                 descriptor valid (ISSUE state)
//   o_row_number            systolic row for this pixel
//   o_o_x, o_o_y            output coordinates
//   o_addr                  input-map address for this pixel
//   o_ch                    current channel group
//   o_busy, o_done          not-IDLE / in-DONE status
// -----------------------------------------------------------------------------
module router_tile_scheduler #(
  parameter int SA_HEIGHT  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int STRIDE_W   = 2,
  parameter int CH_W       = 4,
  localparam int RB        = $clog2(SA_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_reg_clear,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_width,
  input  logic [ADDR_WIDTH-1:0] i_o_width,
  input  logic [ADDR_WIDTH-1:0] i_o_height,
  input  logic [STRIDE_W-1:0]   i_stride,
  input  logic [CH_W-1:0]       i_ch_groups,
  input  logic                  i_ready,
  input  logic                  i_compute_done,
  output logic                  o_valid,
  output logic [RB-1:0]         o_row_number,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [CH_W-1:0]       o_ch,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched configuration
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] pitch_q, pitch_d;
  logic [ADDR_WIDTH-1:0] w_q, w_d;
  logic [ADDR_WIDTH-1:0] h_q, h_d;
  logic [STRIDE_W-1:0]   s_q, s_d;    // effective stride, never 0
  logic [CH_W-1:0]       c_q, c_d;

  // Walk counters and address state
  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d;
  logic [RB-1:0]         row_q, row_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] x_off_q, x_off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_taken_q, last_taken_d; // final pixel of this channel issued

  logic                  cfg_ok;
  logic                  fire;
  logic                  last_pix;
  logic                  batch_end;
  logic                  more_ch;
  logic [ADDR_WIDTH-1:0] row_step;

  assign cfg_ok    = (i_o_width != '0) && (i_o_height != '0) && (i_ch_groups != '0);
  assign fire      = (state_q == S_ISSUE) && i_ready;
  assign last_pix  = (x_q == w_q - ADDR_WIDTH'(1)) && (y_q == h_q - ADDR_WIDTH'(1));
  assign batch_end = (row_q == RB'(SA_HEIGHT - 1)) || last_pix;
  assign more_ch   = (ch_q != c_q - CH_W'(1));

  // S*pitch as a shift-and-add over the few stride bits; no multiplier needed.
  always_comb begin
    row_step = '0;
    for (int b = 0; b < STRIDE_W; b++) begin
      if (s_q[b]) row_step = row_step + (pitch_q << b);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (i_reg_clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (i_en) state_d = cfg_ok ? S_ISSUE : S_DONE;
        S_ISSUE: if (fire && batch_end) state_d = S_WAIT;
        S_WAIT:  if (i_compute_done) state_d = (!last_taken_q || more_ch) ? S_ISSUE : S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid = (state_q == S_ISSUE);
    o_busy  = (state_q != S_IDLE);
    o_done  = (state_q == S_DONE);
  end

  assign o_row_number = row_q;
  assign o_o_x        = x_q;
  assign o_o_y        = y_q;
  assign o_addr       = addr_q;
  assign o_ch         = ch_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    start_d      = start_q;
    pitch_d      = pitch_q;
    w_d          = w_q;
    h_d          = h_q;
    s_d          = s_q;
    c_d          = c_q;
    x_d          = x_q;
    y_d          = y_q;
    row_d        = row_q;
    ch_d         = ch_q;
    row_base_d   = row_base_q;
    x_off_d      = x_off_q;
    addr_d       = addr_q;
    last_taken_d = last_taken_q;

    if (i_reg_clear) begin
      x_d          = '0;
      y_d          = '0;
      row_d        = '0;
      ch_d         = '0;
      row_base_d   = '0;
      x_off_d      = '0;
      addr_d       = '0;
      last_taken_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_en) begin
            start_d      = i_start_addr;
            pitch_d      = i_i_width;
            w_d          = i_o_width;
            h_d          = i_o_height;
            s_d          = (i_stride == '0) ? STRIDE_W'(1) : i_stride;
            c_d          = i_ch_groups;
            x_d          = '0;
            y_d          = '0;
            row_d        = '0;
            ch_d         = '0;
            row_base_d   = i_start_addr;
            x_off_d      = '0;
            addr_d       = i_start_addr;
            last_taken_d = 1'b0;
          end
        end
        S_ISSUE: begin
          if (fire) begin
            if (x_q == w_q - ADDR_WIDTH'(1)) begin
              x_d        = '0;
              x_off_d    = '0;
              y_d        = y_q + ADDR_WIDTH'(1);
              row_base_d = row_base_q + row_step;
            end else begin
              x_d     = x_q + ADDR_WIDTH'(1);
              x_off_d = x_off_q + ADDR_WIDTH'(s_q);
            end
            row_d        = batch_end ? '0 : row_q + RB'(1);
            last_taken_d = last_taken_q | last_pix;
            addr_d       = row_base_d + x_off_d;
          end
        end
        S_WAIT: begin
          // Map exhausted but more channel groups: rewind the walk.
          if (i_compute_done && last_taken_q && more_ch) begin
            ch_d         = ch_q + CH_W'(1);
            x_d          = '0;
            y_d          = '0;
            row_base_d   = start_q;
            x_off_d      = '0;
            addr_d       = start_q;
            last_taken_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all registers here are small control state, so all of them are reset;
  // there is no memory array that could be left unreset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_q      <= '0;
      pitch_q      <= '0;
      w_q          <= '0;
      h_q          <= '0;
      s_q          <= '0;
      c_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      row_base_q   <= '0;
      x_off_q      <= '0;
      addr_q       <= '0;
      last_taken_q <= 1'b0;
    end else begin
      start_q      <= start_d;
      pitch_q      <= pitch_d;
      w_q          <= w_d;
      h_q          <= h_d;
      s_q          <= s_d;
      c_q          <= c_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      ch_q         <= ch_d;
      row_base_q   <= row_base_d;
      x_off_q      <= x_off_d;
      addr_q       <= addr_d;
      last_taken_q <= last_taken_d;
    end
  end

endmodule

// File: tb/tb_router_tile_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for router_tile_scheduler. The reference model expands each job
// into the ordered list of pixel descriptors it should produce. Each pixel's
// address is computed with plain arithmetic, and its row and batch boundaries
// come from the pixel's index within its channel pass.
// -----------------------------------------------------------------------------
module tb_router_tile_scheduler;

  localparam int SA = 4;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int RB = $clog2(SA);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          reg_clear = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] i_width = '0;
  logic [AW-1:0] o_width = '0;
  logic [AW-1:0] o_height = '0;
  logic [SW-1:0] stride = '0;
  logic [CW-1:0] ch_groups = '0;
  logic          ready = 1'b0;
  logic          compute_done = 1'b0;
  logic          valid;
  logic [RB-1:0] row_number;
  logic [AW-1:0] o_x;
  logic [AW-1:0] o_y;
  logic [AW-1:0] addr;
  logic [CW-1:0] ch;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int x;
    int y;
    int addr;
    int row;
    int ch;
    bit last;
  } pix_t;

  pix_t exp_q[$];

  router_tile_scheduler #(
    .SA_HEIGHT (SA),
    .ADDR_WIDTH(AW),
    .STRIDE_W  (SW),
    .CH_W      (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_reg_clear   (reg_clear),
    .i_start_addr  (start_addr),
    .i_i_width     (i_width),
    .i_o_width     (o_width),
    .i_o_height    (o_height),
    .i_stride      (stride),
    .i_ch_groups   (ch_groups),
    .i_ready       (ready),
    .i_compute_done(compute_done),
    .o_valid       (valid),
    .o_row_number  (row_number),
    .o_o_x         (o_x),
    .o_o_y         (o_y),
    .o_addr        (addr),
    .o_ch          (ch),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // Expected descriptor stream for one job.
  task automatic build_model(input int w, input int h, input int s, input int iw,
                             input int st, input int c);
    int seff;
    pix_t p;
    exp_q.delete();
    seff = (s == 0) ? 1 : s;
    for (int cc = 0; cc < c; cc++) begin
      for (int i = 0; i < w * h; i++) begin
        p.x    = i % w;
        p.y    = i / w;
        p.addr = (st + p.y * seff * iw + p.x * seff) % 256;
        p.row  = i % SA;
        p.ch   = cc;
        p.last = ((i % SA) == SA - 1) || (i == w * h - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Drive config and pulse i_en; afterwards scramble the config inputs.
  task automatic start_job(input int w, input int h, input int s, input int iw,
                           input int st, input int c);
    o_width    = AW'(w);
    o_height   = AW'(h);
    stride     = SW'(s);
    i_width    = AW'(iw);
    start_addr = AW'(st);
    ch_groups  = CW'(c);
    en         = 1'b1;
    @(negedge clk);
    en         = 1'b0;
    o_width    = AW'($urandom);
    o_height   = AW'($urandom);
    stride     = SW'($urandom);
    i_width    = AW'($urandom);
    start_addr = AW'($urandom);
    ch_groups  = CW'($urandom);
  endtask

  task automatic check_idle_zero(input string name);
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || o_x !== '0 || o_y !== '0 ||
        addr !== '0 || row_number !== '0 || ch !== '0) begin
      fails++;
      $display("FAIL %s: got v=%b busy=%b done=%b x=%0d y=%0d addr=%0d row=%0d ch=%0d, want all 0",
               name, valid, busy, done, o_x, o_y, addr, row_number, ch);
    end
  endtask

  // Play the expected stream against the DUT. rdy_pct<0 selects a fixed
  // 3-cycle stall on job cycles 2..4; done_delay<0 selects a random WAIT length.
  task automatic run_pixels(input string name, input int rdy_pct, input int done_delay);
    int  idx = 0;
    int  cyc = 0;
    int  d;
    bit  rdy;
    while (idx < exp_q.size() && cyc < 4000) begin
      cyc++;
      tests++;
      if (valid !== 1'b1 || o_x !== AW'(exp_q[idx].x) || o_y !== AW'(exp_q[idx].y) ||
          addr !== AW'(exp_q[idx].addr) || row_number !== RB'(exp_q[idx].row) ||
          ch !== CW'(exp_q[idx].ch)) begin
        fails++;
        $display("FAIL %s pix%0d: got v=%b x=%0d y=%0d addr=%0d row=%0d ch=%0d, want v=1 x=%0d y=%0d addr=%0d row=%0d ch=%0d",
                 name, idx, valid, o_x, o_y, addr, row_number, ch, exp_q[idx].x,
                 exp_q[idx].y, exp_q[idx].addr, exp_q[idx].row, exp_q[idx].ch);
      end
      if (rdy_pct < 0) rdy = !(cyc >= 2 && cyc <= 4);
      else             rdy = ($urandom_range(99) < rdy_pct);
      ready = rdy;
      @(negedge clk);
      if (rdy) begin
        if (exp_q[idx].last) begin
          ready = 1'b0;
          d = (done_delay < 0) ? int'($urandom_range(3)) : done_delay;
          for (int k = 0; k <= d; k++) begin
            tests++;
            if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
              fails++;
              $display("FAIL %s wait%0d: got v=%b busy=%b done=%b, want v=0 busy=1 done=0",
                       name, idx, valid, busy, done);
            end
            if (k < d) @(negedge clk);
          end
          compute_done = 1'b1;
          @(negedge clk);
          compute_done = 1'b0;
        end
        idx++;
      end
    end
    ready = 1'b0;
    if (cyc >= 4000) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d of %0d pixels, want all", name, idx, exp_q.size());
    end
    tests++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s end: got done=%b v=%b busy=%b, want done=1 v=0 busy=1", name, done, valid, busy);
    end
  endtask

  // i_en and i_compute_done in DONE are ignored; i_reg_clear returns to IDLE.
  task automatic finish_job(input string name);
    en = 1'b1;
    compute_done = 1'b1;
    @(negedge clk);
    en = 1'b0;
    compute_done = 1'b0;
    tests++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL %s hold: got done=%b v=%b, want done=1 v=0", name, done, valid);
    end
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    check_idle_zero({name, " clear"});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");
  endtask

  task automatic test_basic();
    build_model(4, 4, 1, 6, 0, 1);
    start_job(4, 4, 1, 6, 0, 1);
    run_pixels("basic", 100, 2);
    finish_job("basic");
  endtask

  task automatic test_stride_partial();
    build_model(3, 2, 2, 7, 10, 1);
    start_job(3, 2, 2, 7, 10, 1);
    run_pixels("stride", 100, -1);
    finish_job("stride");
  endtask

  task automatic test_backpressure();
    build_model(4, 2, 3, 9, 200, 1);
    start_job(4, 2, 3, 9, 200, 1);
    run_pixels("bp", -1, 1);
    finish_job("bp");
  endtask

  task automatic test_channels();
    build_model(2, 2, 1, 5, 3, 3);
    start_job(2, 2, 1, 5, 3, 3);
    run_pixels("chan", 100, -1);
    finish_job("chan");
  endtask

  task automatic test_abort();
    build_model(4, 4, 1, 6, 0, 1);
    start_job(4, 4, 1, 6, 0, 1);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (valid !== 1'b1 || o_x !== AW'(2)) begin
      fails++;
      $display("FAIL abort pre: got v=%b x=%0d, want v=1 x=2", valid, o_x);
    end
    reg_clear = 1'b1;  // coincides with an accepted handshake
    @(negedge clk);
    reg_clear = 1'b0;
    ready = 1'b0;
    check_idle_zero("abort");
    start_job(4, 4, 1, 6, 0, 1);
    run_pixels("abort_restart", 70, -1);
    finish_job("abort_restart");
  endtask

  task automatic test_reset_mid_wait();
    build_model(4, 4, 1, 6, 0, 1);
    start_job(4, 4, 1, 6, 0, 1);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    ready = 1'b0;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b1 || o_y !== AW'(1) || addr !== AW'(6)) begin
      fails++;
      $display("FAIL rst_wait pre: got v=%b busy=%b y=%0d addr=%0d, want v=0 busy=1 y=1 addr=6",
               valid, busy, o_y, addr);
    end
    #2 rst = 1'b1;
    #1 check_idle_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_job(4, 4, 1, 6, 0, 1);
    run_pixels("rst_restart", 100, -1);
    finish_job("rst_restart");
  endtask

  task automatic test_zero_size(input int w, input int h, input int c, input string name);
    start_job(w, h, 1, 5, 7, c);
    tests++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s: got done=%b v=%b busy=%b, want done=1 v=0 busy=1", name, done, valid, busy);
    end
    finish_job(name);
  endtask

  task automatic test_random();
    int w, h, s, iw, st, c;
    for (int j = 0; j < 8; j++) begin
      w  = $urandom_range(1, 6);
      h  = $urandom_range(1, 4);
      s  = $urandom_range(0, 3);
      iw = $urandom_range(0, 255);
      st = $urandom_range(0, 255);
      c  = $urandom_range(1, 3);
      build_model(w, h, s, iw, st, c);
      start_job(w, h, s, iw, st, c);
      run_pixels($sformatf("rand%0d", j), 65, -1);
      finish_job($sformatf("rand%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride_partial();
    test_backpressure();
    test_channels();
    test_abort();
    test_reset_mid_wait();
    test_zero_size(4, 0, 1, "zero_h");
    test_zero_size(0, 3, 2, "zero_w");
    test_zero_size(2, 2, 0, "zero_c");
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
